// File: rtl/led_pattern_ctrl.sv
// LED pattern generator: ALL_ON / BLINK / RUN / PINGPONG stepped every TICK_DIV clocks while vaild is high.
// One register stage from vaild/mode to led; no backpressure, and vaild low blanks the bank on the next edge.
module led_pattern_ctrl #(
    parameter int LED_W   = 4,
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 10
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             vaild,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] led,
    output logic             tick
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    localparam logic [1:0] M_ALL_ON   = 2'd0;
    localparam logic [1:0] M_BLINK    = 2'd1;
    localparam logic [1:0] M_RUN      = 2'd2;
    localparam logic [1:0] M_PINGPONG = 2'd3;

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic               dir_q, dir_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic               tick_q, tick_d;

    logic [LED_W-1:0]   init_led;
    logic [LED_W-1:0]   step_led;
    logic               step_dir;

    always_comb begin
        init_led = LED_W'(1);
        if (mode == M_ALL_ON || mode == M_BLINK) begin
            init_led = '1;
        end
    end

    // One pattern step from the current led/dir; single-LED banks hold still.
    always_comb begin
        step_led = led_q;
        step_dir = dir_q;
        case (mode_q)
            M_BLINK: step_led = ~led_q;
            M_RUN:   step_led = (led_q << 1) | (led_q >> (LED_W - 1));
            M_PINGPONG: begin
                if (LED_W > 1) begin
                    if (!dir_q) begin
                        step_led = led_q << 1;
                        if (step_led[LED_W-1]) step_dir = 1'b1;
                    end else begin
                        step_led = led_q >> 1;
                        if (step_led[0]) step_dir = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        led_d   = led_q;
        tick_d  = 1'b0;
        if (!vaild) begin
            state_d = IDLE;
            cnt_d   = '0;
            led_d   = '0;
        end else if (state_q == IDLE || mode != mode_q) begin
            state_d = RUN;
            mode_d  = mode;
            cnt_d   = '0;
            dir_d   = 1'b0;
            led_d   = init_led;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            led_d  = step_led;
            dir_d  = step_dir;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            dir_q   <= 1'b0;
            led_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            led_q   <= led_d;
            tick_q  <= tick_d;
        end
    end

    assign led  = led_q;
    assign tick = tick_q;
endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Parametrised LED pattern generator: the next generation of the board's default-LED block, driving a configurable-width LED bank. While `vaild` is high it produces one of four run-time-selectable patterns (all-on, blink, running light, ping-pong), stepped by an internal tick divider. While `vaild` is low the bank is dark. It sits between the top-level control logic and the LED pins.

## Interface
- `LED_W`, 4: number of LEDs; legal range 1..32.
- `CLK_HZ`, 50_000_000: `sys_clk` frequency in Hz.
- `TICK_HZ`, 10: pattern step rate in Hz. Derived `TICK_DIV = CLK_HZ / TICK_HZ` (integer division); `TICK_DIV` ≥ 2 required. Counter width is `$clog2(TICK_DIV)`.

- `sys_clk`  input  1  system clock, all logic on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `vaild`  input  1  enable; 1 runs the selected pattern, 0 forces LEDs off.
- `mode`  input  2  pattern select: 0 ALL_ON, 1 BLINK, 2 RUN, 3 PINGPONG.
- `led`  output  LED_W  LED drive, registered, 1 = lit.
- `tick`  output  1  registered one-cycle pulse on every pattern step.

## Operation
- States: IDLE, RUN. Internal registers: `cnt`, `mode_q` (2 b), `dir` (0 = left/up, 1 = right/down), `led`, `tick`.
- Reset (`rst_n`=0 at an edge): state IDLE, `led`=0, `tick`=0, `cnt`=0, `mode_q`=0, `dir`=0. Reset has priority over every other input, including mid-pattern.
- IDLE, `vaild`=0: hold `led`=0, `cnt`=0, `tick`=0.
- Load event: either IDLE with `vaild`=1, or RUN with `vaild`=1 and `mode`≠`mode_q`. On a load event: state RUN, `mode_q`←`mode`, `cnt`←0, `dir`←0, `tick`←0, `led`←init pattern.
- Init patterns: ALL_ON all ones; BLINK all ones; RUN `1` (LSB); PINGPONG `1` (LSB).
- RUN, `vaild`=1, same mode: `cnt` increments. When `cnt`=`TICK_DIV`-1: `cnt`←0, `tick`←1, `led`←next pattern. Otherwise `tick`←0.
- Next pattern:
  - ALL_ON: unchanged.
  - BLINK: bitwise invert.
  - RUN: rotate left by 1; the MSB wraps to the LSB.
  - PINGPONG, `dir`=0: shift left. If the result has its MSB set, `dir`←1.
  - PINGPONG, `dir`=1: shift right. If the result has its LSB set, `dir`←0.
  - The result is always one-hot and never leaves the bank.
- `LED_W`=1: RUN and PINGPONG hold `led`=1. `dir` stays 0.
- RUN with `vaild`=0: next edge goes to IDLE with `led`=0, `cnt`=0, `tick`=0. A later `vaild`=1 is a fresh load; the pattern does not resume.
- `vaild` and a mode change in the same cycle are a single load event, handled as above.
- `tick` fires in ALL_ON mode as well, even though `led` does not change.

## Timing
- Load latency: `vaild`/`mode` sampled at edge k; the init pattern is on `led` after edge k (one register stage).
- First step is visible after edge k+`TICK_DIV`. Subsequent steps come every `TICK_DIV` cycles.
- `tick` is high for exactly the cycle following the edge that updated `led`, and is coincident with the new `led` value.
- Blank latency: `vaild`=0 sampled at edge k gives `led`=0 after edge k.
- RUN period is `LED_W` ticks. PINGPONG period is 2·(`LED_W`−1) ticks for `LED_W`≥2. BLINK period is 2 ticks.

## Test plan
Bench configuration: `LED_W`=4, `CLK_HZ`=40, `TICK_HZ`=10, so `TICK_DIV`=4.
- Reset, then `vaild`=0 for 20 cycles -> `led`=0000 and `tick`=0 throughout.
- `vaild`=1, `mode`=2 -> `led`=0001 at the next edge. Steps then go 0010, 0100, 1000, 0001, each 4 cycles apart, with one `tick` per step.
- `mode`=3 held for 14 ticks -> 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …, never 0000. `dir` flips at 1000 and at 0001.
- `mode`=1 -> 1111, 0000, 1111, 0000 every 4 cycles. Then switch to `mode`=0 -> 1111 next edge, with `tick` continuing every 4 cycles and `led` unchanged.
- Mid-pattern in mode 2 at `led`=0100, change `mode` to 3 -> `led`=0001 next edge and `cnt` restarts, so the next step is exactly 4 cycles later. Drop `vaild` -> 0000 next edge. Raise it again -> 0001, not resumed.
- Assert `rst_n`=0 for one cycle mid-PINGPONG with `dir`=1 -> all outputs 0 next edge. With `vaild`=1 after release, the bank restarts at 0001 moving left.
